// File: rtl/gain_select_ctrl_if.sv
// Gain command handshake between a controller and gain_select_ctrl.
// The master offers a gain code and the block accepts it when cmd_ready is high.
interface gain_select_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_gain;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_gain, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_gain, output cmd_ready);
endinterface

// File: rtl/gain_select_ctrl.sv
// Break-before-make sequencer for a 3-input analog gain mux: disables the mux,
// waits a dead time, changes the selects, lets them settle, then re-enables.
module gain_select_ctrl #(
    parameter int unsigned DEAD_CYC   = 4,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    gain_select_ctrl_if.slave  cmd,
    input  logic               mute,
    output logic               sen,
    output logic               s1,
    output logic               s0,
    output logic [1:0]         cur_gain,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREAK  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Counters load with N-1 so that exactly N cycles are spent in the state.
    localparam logic [7:0] DEAD_LOAD   = 8'(DEAD_CYC - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

    state_t     state_reg,      state_next;
    logic [7:0] dead_cnt_reg,   dead_cnt_next;
    logic [7:0] settle_cnt_reg, settle_cnt_next;
    logic [1:0] gain_reg,       gain_next;
    logic [1:0] target_reg,     target_next;
    logic       sen_reg,        sen_next;
    logic       done_reg,       done_next;
    logic       err_reg,        err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            dead_cnt_reg   <= 8'd0;
            settle_cnt_reg <= 8'd0;
            gain_reg       <= 2'd0;
            target_reg     <= 2'd0;
            sen_reg        <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dead_cnt_reg   <= dead_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            gain_reg       <= gain_next;
            target_reg     <= target_next;
            sen_reg        <= sen_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        dead_cnt_next   = dead_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        gain_next       = gain_reg;
        target_next     = target_reg;
        sen_next        = sen_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                sen_next = ~mute;
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_gain == 2'd3) begin
                        err_next = 1'b1;
                    end else if (cmd.cmd_gain == gain_reg) begin
                        done_next = 1'b1;
                    end else begin
                        state_next    = BREAK;
                        target_next   = cmd.cmd_gain;
                        dead_cnt_next = DEAD_LOAD;
                        sen_next      = 1'b0;
                    end
                end
            end
            BREAK: begin
                if (dead_cnt_reg == 8'd0) begin
                    state_next      = SETTLE;
                    gain_next       = target_reg;
                    settle_cnt_next = SETTLE_LOAD;
                end else begin
                    dead_cnt_next = dead_cnt_reg - 8'd1;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == 8'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    // Mute changes during the sequence only matter here.
                    sen_next   = ~mute;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd.cmd_ready = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign sen           = sen_reg;
    assign s1            = gain_reg[1];
    assign s0            = gain_reg[0];
    assign cur_gain      = gain_reg;
    assign done          = done_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_gain_select_ctrl.sv
// Self-checking bench for gain_select_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a timestamp-based model.
module tb_gain_select_ctrl;

    localparam int D = 4;
    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       mute;
    logic       sen, s1, s0, busy, done, err;
    logic [1:0] cur_gain;

    gain_select_ctrl_if cmd_if();

    gain_select_ctrl #(.DEAD_CYC(D), .SETTLE_CYC(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .mute     (mute),
        .sen      (sen),
        .s1       (s1),
        .s0       (s0),
        .cur_gain (cur_gain),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: a sequence is a pair of timestamps (switch edge, completion edge).
    int         edge_n   = 0;
    int         txn_n    = 0;
    bit         m_in_seq = 1'b0;
    int         m_sw_at  = 0;
    int         m_done_at = 0;
    logic [1:0] m_pend   = 2'd0;
    logic       exp_sen  = 1'b0;
    logic       exp_done = 1'b0;
    logic       exp_err  = 1'b0;
    logic [1:0] exp_gain = 2'd0;

    initial begin
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            if (rst) begin
                m_in_seq = 1'b0;
                exp_sen  = 1'b0;
                exp_gain = 2'd0;
                exp_done = 1'b0;
                exp_err  = 1'b0;
            end else begin
                exp_done = 1'b0;
                exp_err  = 1'b0;
                if (!m_in_seq) begin
                    exp_sen = !mute;
                    if (cmd_if.cmd_valid) begin
                        txn_n++;
                        $display("txn %0d: edge %0d gain=%0d cur=%0d mute=%0d", txn_n, edge_n,
                                 cmd_if.cmd_gain, exp_gain, mute);
                        if (cmd_if.cmd_gain == 2'd3) begin
                            exp_err = 1'b1;
                        end else if (cmd_if.cmd_gain == exp_gain) begin
                            exp_done = 1'b1;
                        end else begin
                            m_in_seq  = 1'b1;
                            m_pend    = cmd_if.cmd_gain;
                            m_sw_at   = edge_n + D;
                            m_done_at = edge_n + D + S;
                            exp_sen   = 1'b0;
                        end
                    end
                end else begin
                    if (edge_n == m_sw_at) exp_gain = m_pend;
                    if (edge_n == m_done_at) begin
                        m_in_seq = 1'b0;
                        exp_done = 1'b1;
                        exp_sen  = !mute;
                    end
                end
            end
        end
    end

    logic [1:0] prev_sel = 2'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("sen",      sen,              exp_sen);
                check("sel",      {s1, s0},         exp_gain);
                check("cur_gain", cur_gain,         exp_gain);
                check("busy",     busy,             m_in_seq);
                check("ready",    cmd_if.cmd_ready, !m_in_seq);
                check("done",     done,             exp_done);
                check("err",      err,              exp_err);
                check("done_err", done & err,       0);
                if ({s1, s0} != prev_sel) check("bbm_sen", sen, 0);
            end
            prev_sel = {s1, s0};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [1:0] g, input logic sen_at_done);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_gain  = g;
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("seq_busy", busy, 1);
        check("seq_sen0", sen, 0);
        repeat (D + S) tick();
        check("seq_done", done, 1);
        check("seq_cur", cur_gain, g);
        check("seq_sen_end", sen, sen_at_done);
    endtask

    initial begin
        rst              = 1'b1;
        mute             = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_gain  = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_sen",   sen, 0);
        check("rst_sel",   {s1, s0}, 0);
        check("rst_cur",   cur_gain, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);
        chk_en = 1'b1;
        tick();
        check("rel_sen", sen, 1);
        tick();

        // Default timing, gain 0 -> 2
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_gain  = 2'd2;
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("t1_sen", sen, 0);
        check("t1_busy", busy, 1);
        repeat (3) tick();
        check("t4_sel", {s1, s0}, 2'b00);
        tick();
        check("t5_sel", {s1, s0}, 2'b10);
        check("t5_model", exp_gain, 2);
        repeat (15) tick();
        check("t20_sen", sen, 0);
        check("t20_done", done, 0);
        tick();
        check("t21_done", done, 1);
        check("t21_sen", sen, 1);
        check("t21_ready", cmd_if.cmd_ready, 1);
        check("t21_model", exp_done, 1);

        // Illegal gain
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_gain  = 2'd3;
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("ill_err", err, 1);
        check("ill_done", done, 0);
        check("ill_sel", {s1, s0}, 2'b10);
        check("ill_sen", sen, 1);
        check("ill_ready", cmd_if.cmd_ready, 1);

        // Same gain is a no-op that still completes
        run_seq(2'd1, 1'b1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_gain  = 2'd1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("same_done", done, 1);
        check("same_busy", busy, 0);
        check("same_sen", sen, 1);
        tick();
        check("same_busy2", busy, 0);

        // Command held during a sequence is taken only at completion
        run_seq(2'd0, 1'b1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_gain  = 2'd1;
        tick();
        cmd_if.cmd_gain  = 2'd2;
        check("hold_ready_t1", cmd_if.cmd_ready, 0);
        for (int i = 2; i <= D + S; i++) begin
            tick();
            check("hold_ready", cmd_if.cmd_ready, 0);
        end
        tick();
        check("hold_done", done, 1);
        check("hold_ready_end", cmd_if.cmd_ready, 1);
        check("hold_cur1", cur_gain, 1);
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("hold_busy2", busy, 1);
        check("hold_sen2", sen, 0);
        repeat (D + S) tick();
        check("hold_done2", done, 1);
        check("hold_cur2", cur_gain, 2);

        // Reset in the middle of a sequence
        run_seq(2'd0, 1'b1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_gain  = 2'd2;
        tick();
        cmd_if.cmd_valid = 1'b0;
        repeat (7) tick();
        check("ab_pre_cur", cur_gain, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ab_sen", sen, 0);
        check("ab_sel", {s1, s0}, 2'b00);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        tick();
        tick();
        run_seq(2'd2, 1'b1);

        // Mute handling
        mute = 1'b1;
        tick();
        check("mute_sen", sen, 0);
        run_seq(2'd1, 1'b0);
        mute = 1'b0;
        tick();
        check("unmute_sen", sen, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_if.cmd_gain  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mute = ~mute;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        repeat (D + S + 4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
